// File: rtl/ife_pkg.sv
// Shared IFE types and default widths, used by the block arbiter and the block queue.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package ife_pkg;

  // Index width for a vector of n entries; at least one bit so a single-entry index still exists
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_BLOCK_ID_WIDTH = 8;
  localparam int DEF_INSTR_WIDTH    = 32;
  localparam int DEF_BLOCK_SIZE     = 4;
  localparam int DEF_MAX_INFLIGHT   = 16;
  localparam int DEF_SRC_WIDTH      = src_width(DEF_NUM_REQ);

  // One fetch block as it sits in the block queue
  typedef struct packed {
    logic [DEF_BLOCK_ID_WIDTH-1:0]                     id;
    logic [DEF_BLOCK_SIZE-1:0][DEF_INSTR_WIDTH-1:0]    instrs;
  } block_t;

endpackage

// File: rtl/ife_block_arbiter_if.sv
// Requester/queue-side bundle of the IFE block arbiter.
// Latency: n/a (wires only).
// Backpressure: req_ready toward producers, ready_downstream from the queue.
interface ife_block_arbiter_if
  import ife_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int BLOCK_ID_WIDTH = DEF_BLOCK_ID_WIDTH,
  parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
  parameter int BLOCK_SIZE     = DEF_BLOCK_SIZE,
  parameter int MAX_INFLIGHT   = DEF_MAX_INFLIGHT
) ();

  localparam int SRC_W = src_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [NUM_REQ-1:0]                                req_valid;
  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] req_block;
  logic [NUM_REQ-1:0]                                req_ready;
  logic [BLOCK_ID_WIDTH-1:0]                         block_id_out;
  logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0]            block_out;
  logic [SRC_W-1:0]                                  src_out;
  logic                                              valid_out;
  logic                                              ready_downstream;
  logic                                              retire;
  logic [CNT_W-1:0]                                  inflight_cnt;
  logic                                              err_underflow;

  // Producers, queue and retire logic
  modport master (
    output req_valid, req_block, ready_downstream, retire,
    input  req_ready, block_id_out, block_out, src_out, valid_out, inflight_cnt, err_underflow
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_block, ready_downstream, retire,
    output req_ready, block_id_out, block_out, src_out, valid_out, inflight_cnt, err_underflow
  );

endinterface

// File: rtl/ife_rr_picker.sv
// Round-robin winner search: first asserted request at or after rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; found=0 when no request is asserted.
module ife_rr_picker
  import ife_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int SRC_W   = src_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [SRC_W-1:0]   winner,
  output logic               found
);

  logic [SRC_W-1:0] idx;

  // Walk the requesters starting at rr_ptr and keep the first one that is asserted
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = SRC_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ife_block_arbiter.sv
// Round-robin share of the IFE block queue among NUM_REQ producers, with ID/source stamping and an in-flight cap.
// Latency: 1 cycle from accept to valid_out; 1 block/cycle sustained.
// Backpressure: no grant while the output stage is held (valid_out && !ready_downstream) or MAX_INFLIGHT is reached.
module ife_block_arbiter
  import ife_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int BLOCK_ID_WIDTH = DEF_BLOCK_ID_WIDTH,
  parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
  parameter int BLOCK_SIZE     = DEF_BLOCK_SIZE,
  parameter int MAX_INFLIGHT   = DEF_MAX_INFLIGHT
) (
  input  logic                clk,
  input  logic                rst_n,
  ife_block_arbiter_if.slave  bus
);

  localparam int SRC_W = src_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  typedef logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] payload_t;

  logic                      valid_q;
  payload_t                  block_q;
  logic [BLOCK_ID_WIDTH-1:0] id_q;
  logic [BLOCK_ID_WIDTH-1:0] next_id;
  logic [SRC_W-1:0]          src_q;
  logic [SRC_W-1:0]          rr_ptr;
  logic [CNT_W-1:0]          cnt_q;
  logic                      err_q;

  logic [SRC_W-1:0]          winner;
  logic                      found;
  logic                      slot_free;
  logic                      can_issue;
  logic                      accept;
  logic                      retire_eff;

  ife_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_picker (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .found  (found)
  );

  // Issue only into a free output slot and below the cap; a same-cycle retire does not count.
  // Gating with rst_n keeps any handshake from completing while reset is asserted.
  assign slot_free  = !valid_q || bus.ready_downstream;
  assign can_issue  = rst_n && slot_free && (cnt_q < CNT_W'(MAX_INFLIGHT));
  assign accept     = can_issue && found;
  assign retire_eff = bus.retire && (cnt_q != '0);

  // One-hot grant to the round-robin winner, or nothing
  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[winner] = 1'b1;
    end
  end

  // Output stage, block ID counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      block_q <= '0;
      id_q    <= '0;
      src_q   <= '0;
      next_id <= '0;
      rr_ptr  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      block_q <= bus.req_block[winner];
      src_q   <= winner;
      id_q    <= next_id;
      next_id <= next_id + 1'b1;
      rr_ptr  <= (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (valid_q && bus.ready_downstream) begin
      valid_q <= 1'b0;
    end
  end

  // In-flight count and sticky underflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept && !retire_eff) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!accept && retire_eff) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (bus.retire && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.valid_out     = valid_q;
  assign bus.block_out     = block_q;
  assign bus.block_id_out  = id_q;
  assign bus.src_out       = src_q;
  assign bus.inflight_cnt  = cnt_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_ife_block_arbiter.sv
// Bench for ife_block_arbiter: reference model compared every cycle, directed phases with literal expectations, then random traffic.
module tb_ife_block_arbiter;

  localparam int NR   = 4;
  localparam int SW   = 2;
  localparam int IDW  = 8;
  localparam int IW   = 32;
  localparam int BS   = 4;
  localparam int MAXI = 16;
  localparam int PW   = IW * BS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ife_block_arbiter_if #(
    .NUM_REQ(NR), .BLOCK_ID_WIDTH(IDW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS), .MAX_INFLIGHT(MAXI)
  ) bus ();

  ife_block_arbiter #(
    .NUM_REQ(NR), .BLOCK_ID_WIDTH(IDW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit            m_valid = 0;
  int            m_id = 0, m_src = 0, m_next = 0, m_ptr = 0, m_cnt = 0;
  bit            m_err = 0;
  logic [PW-1:0] m_blk = '0;
  bit            m_acc = 0;
  int            m_w = 0;

  // Stimulus knobs and requester state
  int            ready_pct = 100, retire_pct = 0, fill_pct = 100;
  bit            n_rst = 0, flush = 0;
  logic [NR-1:0] rv;
  logic [PW-1:0] rb [NR];
  logic [PW-1:0] exp_blk;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model outputs versus DUT, then the model decides this cycle's accept
  task automatic compare();
    logic [NR-1:0] er;
    bit can, fnd;
    int w, j;
    can = rst_n && (!m_valid || bus.ready_downstream) && (m_cnt < MAXI);
    fnd = 0;
    w   = 0;
    for (int k = 0; k < NR; k++) begin
      j = (m_ptr + k) % NR;
      if (!fnd && rv[SW'(j)]) begin
        fnd = 1;
        w   = j;
      end
    end
    er = '0;
    if (can && fnd) er[SW'(w)] = 1'b1;
    chk("req_ready",     PW'(bus.req_ready),     PW'(er));
    chk("valid_out",     PW'(bus.valid_out),     PW'(m_valid));
    chk("block_id_out",  PW'(bus.block_id_out),  PW'(m_id));
    chk("src_out",       PW'(bus.src_out),       PW'(m_src));
    chk("block_out",     PW'(bus.block_out),     m_blk);
    chk("inflight_cnt",  PW'(bus.inflight_cnt),  PW'(m_cnt));
    chk("err_underflow", PW'(bus.err_underflow), PW'(m_err));
    m_acc = can && fnd;
    m_w   = w;
  endtask

  // Model state update at the clock edge
  task automatic model_update();
    int dec;
    if (!rst_n) begin
      m_valid = 0; m_id = 0; m_src = 0; m_blk = '0;
      m_cnt = 0; m_err = 0; m_ptr = 0; m_next = 0;
    end else begin
      dec = (bus.retire && m_cnt > 0) ? 1 : 0;
      if (bus.retire && m_cnt == 0) m_err = 1;
      if (m_acc) begin
        m_valid = 1;
        m_blk   = rb[m_w];
        m_src   = m_w;
        m_id    = m_next;
        m_next  = (m_next + 1) % (1 << IDW);
        m_ptr   = (m_w + 1) % NR;
      end else if (m_valid && bus.ready_downstream) begin
        m_valid = 0;
      end
      m_cnt = m_cnt + (m_acc ? 1 : 0) - dec;
    end
  endtask

  // New inputs just after the edge; a request is held until it has been accepted
  task automatic drive();
    rst_n = n_rst;
    for (int i = 0; i < NR; i++) begin
      if (m_acc && m_w == i) rv[SW'(i)] = 1'b0;
      if (flush) begin
        rv[SW'(i)] = 1'b0;
      end else if (!rv[SW'(i)] && $urandom_range(0, 99) < fill_pct) begin
        rv[SW'(i)] = 1'b1;
        rb[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.req_block[SW'(i)] = rb[i];
    end
    bus.req_valid        = rv;
    bus.ready_downstream = ($urandom_range(0, 99) < ready_pct);
    bus.retire           = ($urandom_range(0, 99) < retire_pct);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    drive();
    @(negedge clk);
    compare();
  endtask

  initial begin
    rst_n = 1'b0;
    rv    = '1;
    for (int i = 0; i < NR; i++) begin
      rb[i] = {$urandom, $urandom, $urandom, $urandom};
      bus.req_block[SW'(i)] = rb[i];
    end
    bus.req_valid        = rv;
    bus.ready_downstream = 1'b1;
    bus.retire           = 1'b0;

    // Reset held with every requester asserting
    repeat (3) cycle();
    chk("rst_req_ready", PW'(bus.req_ready),     PW'(0));
    chk("rst_valid",     PW'(bus.valid_out),     PW'(0));
    chk("rst_cnt",       PW'(bus.inflight_cnt),  PW'(0));
    chk("rst_err",       PW'(bus.err_underflow), PW'(0));

    // Release: requester 0 first, then strict rotation up to the cap
    n_rst = 1;
    cycle();
    chk("first_grant", PW'(bus.req_ready), PW'(4'b0001));
    for (int k = 0; k < 16; k++) begin
      cycle();
      chk("fair_valid", PW'(bus.valid_out),    PW'(1));
      chk("fair_src",   PW'(bus.src_out),      PW'(k % 4));
      chk("fair_id",    PW'(bus.block_id_out), PW'(k));
      chk("fair_cnt",   PW'(bus.inflight_cnt), PW'(k + 1));
    end
    chk("cap_ready", PW'(bus.req_ready), PW'(0));
    cycle();
    chk("cap_drain_valid", PW'(bus.valid_out),    PW'(0));
    chk("cap_hold_cnt",    PW'(bus.inflight_cnt), PW'(16));

    // Single retire frees exactly one slot
    retire_pct = 100;
    cycle();
    chk("retire_no_raise", PW'(bus.req_ready), PW'(0));
    retire_pct = 0;
    cycle();
    chk("retire_cnt",   PW'(bus.inflight_cnt), PW'(15));
    chk("retire_grant", PW'(bus.req_ready),    PW'(4'b0001));
    cycle();
    chk("refill_cnt", PW'(bus.inflight_cnt), PW'(16));
    chk("refill_src", PW'(bus.src_out),      PW'(0));
    chk("refill_id",  PW'(bus.block_id_out), PW'(16));

    // Simultaneous accept and retire keeps the count
    retire_pct = 100;
    cycle();
    cycle();
    chk("acc_ret_cnt0",  PW'(bus.inflight_cnt), PW'(15));
    chk("acc_ret_grant", PW'(bus.req_ready),    PW'(4'b0010));
    cycle();
    chk("acc_ret_cnt1", PW'(bus.inflight_cnt), PW'(15));
    chk("acc_ret_src",  PW'(bus.src_out),      PW'(1));
    chk("acc_ret_id",   PW'(bus.block_id_out), PW'(17));
    retire_pct = 0;

    // Mid-stream reset, then underflow
    n_rst = 0;
    cycle();
    chk("midrst_ready", PW'(bus.req_ready), PW'(0));
    flush = 1;
    cycle();
    chk("midrst_valid", PW'(bus.valid_out),    PW'(0));
    chk("midrst_id",    PW'(bus.block_id_out), PW'(0));
    chk("midrst_block", bus.block_out,         PW'(0));
    chk("midrst_cnt",   PW'(bus.inflight_cnt), PW'(0));
    n_rst = 1;
    retire_pct = 100;
    cycle();
    cycle();
    chk("uflow_err", PW'(bus.err_underflow), PW'(1));
    chk("uflow_cnt", PW'(bus.inflight_cnt),  PW'(0));
    retire_pct = 0;
    cycle();
    cycle();
    chk("uflow_sticky", PW'(bus.err_underflow), PW'(1));

    // Backpressure: first block held while the queue is not ready
    flush = 0;
    ready_pct = 0;
    cycle();
    chk("bp_grant", PW'(bus.req_ready), PW'(4'b0001));
    exp_blk = rb[0];
    cycle();
    chk("bp_valid", PW'(bus.valid_out),    PW'(1));
    chk("bp_id",    PW'(bus.block_id_out), PW'(0));
    chk("bp_block", bus.block_out,         exp_blk);
    repeat (2) begin
      cycle();
      chk("bp_hold_valid", PW'(bus.valid_out),    PW'(1));
      chk("bp_hold_block", bus.block_out,         exp_blk);
      chk("bp_hold_ready", PW'(bus.req_ready),    PW'(0));
    end
    ready_pct = 100;
    cycle();
    chk("bp_release_grant", PW'(bus.req_ready), PW'(4'b0010));
    cycle();
    chk("bp_next_id",  PW'(bus.block_id_out), PW'(1));
    chk("bp_next_src", PW'(bus.src_out),      PW'(1));

    // Random traffic with occasional resets; enough accepts to wrap the ID
    fill_pct = 60;
    for (int b = 0; b < 8; b++) begin
      ready_pct  = $urandom_range(40, 100);
      retire_pct = $urandom_range(20, 80);
      repeat (500) begin
        n_rst = ($urandom_range(0, 299) != 0);
        cycle();
      end
    end
    n_rst = 1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
